// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register zero, select encodings, ALU codes
// and the packed control bundle carried down the pipeline.
package mips_pkg;
  localparam int          ALU_OP_W = 4;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RD_RT = 2'b00,
    RD_RD = 2'b01,
    RD_RA = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOR  = 4'h5,
    ALU_SLT  = 4'h6,
    ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA,
    ALU_LUI  = 4'hB
  } alu_op_e;

  typedef struct packed {
    logic [1:0]          reg_dst;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic [1:0]          mem_to_reg;
  } ctrl_t;
endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: a load in EX whose destination feeds a source of the
// instruction in ID. Register $0 is never a hazard.
module load_use_detect
  import mips_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [AW-1:0] ex_rt_addr,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic          id_uses_rt,
  output logic          load_use
);
  logic rs_hit, rt_hit;

  assign rs_hit   = (ex_rt_addr == id_rs_addr);
  assign rt_hit   = id_uses_rt & (ex_rt_addr == id_rt_addr);
  assign load_use = ex_valid & ex_mem_read & (ex_rt_addr != AW'(REG_ZERO)) &
                    id_valid & (rs_hit | rt_hit);
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with built-in load-use bubble insertion.
// Optional ID_EX_PERF_CNT_EN adds saturating bubble/flush event counters.
module id_ex_stage_reg
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [DW-1:0]       id_pc_plus4,
  input  logic [DW-1:0]       id_rs_data,
  input  logic [DW-1:0]       id_rt_data,
  input  logic [DW-1:0]       id_imm_ext,
  input  logic [AW-1:0]       id_rs_addr,
  input  logic [AW-1:0]       id_rt_addr,
  input  logic [AW-1:0]       id_rd_addr,
  input  logic                id_uses_rt,
  input  logic [1:0]          id_reg_dst,
  input  logic                id_alu_src,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_reg_write,
  input  logic [1:0]          id_mem_to_reg,
  input  logic                ex_stall,
  input  logic                flush,
  output logic                id_hold,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]         bubble_cnt,
  output logic [31:0]         flush_cnt,
`endif
  output logic                ex_valid,
  output logic [DW-1:0]       ex_pc_plus4,
  output logic [DW-1:0]       ex_rs_data,
  output logic [DW-1:0]       ex_rt_data,
  output logic [DW-1:0]       ex_imm_ext,
  output logic [AW-1:0]       ex_rs_addr,
  output logic [AW-1:0]       ex_rt_addr,
  output logic [AW-1:0]       ex_rd_addr,
  output logic [1:0]          ex_reg_dst,
  output logic                ex_alu_src,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_reg_write,
  output logic [1:0]          ex_mem_to_reg
);
  ctrl_t         id_ctrl, ctrl_q;
  logic          vld_q;
  logic [DW-1:0] pc4_q, rsd_q, rtd_q, imm_q;
  logic [AW-1:0] rsa_q, rta_q, rda_q;
  logic          load_use;

  assign id_ctrl = {id_reg_dst, id_alu_src, id_alu_op, id_mem_read,
                    id_mem_write, id_reg_write, id_mem_to_reg};

  load_use_detect #(.AW(AW)) u_lud (
    .ex_valid    (vld_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rt_addr  (rta_q),
    .id_valid    (id_valid),
    .id_rs_addr  (id_rs_addr),
    .id_rt_addr  (id_rt_addr),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use)
  );

  assign id_hold = load_use | ex_stall;

  // flush beats stall beats load-use; a bubble is simply all-zero state
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush || (!ex_stall && load_use)) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      pc4_q  <= '0;
      rsd_q  <= '0;
      rtd_q  <= '0;
      imm_q  <= '0;
      rsa_q  <= '0;
      rta_q  <= '0;
      rda_q  <= '0;
    end else if (!ex_stall) begin
      vld_q  <= id_valid;
      ctrl_q <= id_ctrl;
      pc4_q  <= id_pc_plus4;
      rsd_q  <= id_rs_data;
      rtd_q  <= id_rt_data;
      imm_q  <= id_imm_ext;
      rsa_q  <= id_rs_addr;
      rta_q  <= id_rt_addr;
      rda_q  <= id_rd_addr;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (!flush && !ex_stall && load_use && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 32'd1;
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

  assign ex_valid      = vld_q;
  assign ex_pc_plus4   = pc4_q;
  assign ex_rs_data    = rsd_q;
  assign ex_rt_data    = rtd_q;
  assign ex_imm_ext    = imm_q;
  assign ex_rs_addr    = rsa_q;
  assign ex_rt_addr    = rta_q;
  assign ex_rd_addr    = rda_q;
  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the MIPS core, with load-use hazard detection built in.
- Captures decoded operands and control from the decode stage, one transfer per cycle.
- Drives the execute-stage select logic: reg_dst picks rt/rd/31, alu_src picks reg/imm, mem_to_reg feeds write-back select.
- Inserts bubbles on load-use hazards and on flush; holds its contents when execute stalls.

Parameters:
- DW, 32, datapath width (pc_plus4, operands, immediate)
- AW, 5, register address width

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous reset, active-high
- id_valid  in  1  decode stage holds a real instruction
- id_pc_plus4  in  DW  PC+4 of the decoded instruction
- id_rs_data, id_rt_data  in  DW  register file read data
- id_imm_ext  in  DW  sign/zero-extended immediate
- id_rs_addr, id_rt_addr, id_rd_addr  in  AW  register specifiers
- id_uses_rt  in  1  instruction reads rt as a source
- id_reg_dst  in  2  00 = rt, 01 = rd, 10 = $31
- id_alu_src  in  1  0 = rt_data, 1 = imm
- id_alu_op  in  4  ALU operation code
- id_mem_read, id_mem_write, id_reg_write  in  1  memory and write-back enables
- id_mem_to_reg  in  2  00 = ALU, 01 = memory, 10 = pc_plus4
- ex_stall  in  1  execute stage cannot accept a new instruction
- flush  in  1  kill the instruction entering EX (branch/jump redirect)
- id_hold  out  1  IF/ID must hold = load_use | ex_stall (combinational)
- ex_valid  out  1  registered valid
- ex_* outputs  out  same widths  registered copies of every id_* field above, except id_valid and id_uses_rt

Behaviour:
- Reset: asynchronous and active-high. While rst = 1, every ex_* output, including ex_valid, is 0 immediately. First capture happens on the first rising edge after rst deasserts.
- load_use = ex_valid & ex_mem_read & (ex_rt_addr != 0) & id_valid & ((ex_rt_addr == id_rs_addr) | (id_uses_rt & ex_rt_addr == id_rt_addr)). Purely combinational from registered state and ID inputs.
- Update priority at each rising edge:
  1. flush: load a bubble.
  2. ex_stall: hold all registers unchanged.
  3. load_use: load a bubble.
  4. Otherwise: capture all id_* fields; ex_valid <= id_valid.
- Bubble: every ex_* output = 0, so ex_valid, ex_reg_write, ex_mem_read and ex_mem_write are 0.
- Latency: 1 cycle from ID to EX. A load-use hazard costs exactly 1 bubble. In the following cycle ex_mem_read = 0, so load_use clears and the held instruction advances.
- flush together with ex_stall: flush wins. The flushed slot becomes a bubble. id_hold still follows ex_stall.
- flush together with load_use: flush wins, producing one bubble.
- An id_valid = 0 input is captured as a not-valid instruction. Its control fields are still captured; downstream qualifies them with ex_valid.
- Register $0 never causes a hazard.
- Reset asserted mid-stall: all contents are dropped; no pending state survives.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds outputs bubble_cnt[31:0] and flush_cnt[31:0].
  - bubble_cnt increments on each edge where a load_use bubble is inserted.
  - flush_cnt increments on each edge where flush is applied.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ZERO constant.
  - reg_dst encodings: RD_RT, RD_RD, RD_RA.
  - mem_to_reg encodings: WB_ALU, WB_MEM, WB_PC4.
  - ALU op width and codes.
  - Packed control typedef ctrl_t: reg_dst, alu_src, alu_op, mem_read, mem_write, reg_write, mem_to_reg.
- One sub-module: load_use_detect, the pure comparator producing load_use.

Test Plan:
- rst pulsed mid-cycle with outputs non-zero -> all ex_* outputs read 0 before the next edge; ex_valid = 0.
- Input lw $8,0($9) then add $10,$8,$11 (rs = 8) -> add sees load_use = 1 and id_hold = 1 for 1 cycle. A bubble is loaded (ex_reg_write = 0), then add reaches EX the next cycle.
- Input lw $0 followed by a consumer of $0 -> no hazard; back-to-back capture.
- Input lw $8 then sw with rt = 8 and id_uses_rt = 1 -> 1 bubble. The same pair with id_uses_rt = 0 and rs = 3 -> no bubble.
- Hold ex_stall for 3 cycles with ex_alu_op = 4'h2 latched -> outputs unchanged for 3 edges and id_hold = 1. Assert flush on the 2nd of those edges -> ex_valid = 0 after that edge.
- With ID_EX_PERF_CNT_EN defined: 2 load-use events and 1 flush -> bubble_cnt = 2, flush_cnt = 1.
